// File: rtl/control_pipeline.sv
// STAGES-deep instruction/control pipeline: each stage holds an instruction and a valid bit,
// exposes {flags, instr} as a microcode-ROM address and gates the returned word into a control word.
module control_pipeline #(
  parameter int                  STAGES        = 2,
  parameter int                  INSTR_W       = 8,
  parameter int                  FLAGS_W       = 7,
  parameter int                  CTRL_W        = 16,
  parameter logic [INSTR_W-1:0]  NOP_INSTR     = '0,
  parameter logic [CTRL_W-1:0]   IDLE_CONTROLS = '1,
  parameter int                  RCOUNT_W      = 16
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [INSTR_W-1:0]                  instruction,
  input  logic                                fetch_suppress,
  input  logic                                stall,
  input  logic [STAGES-1:0]                   flush,
  input  logic [FLAGS_W-1:0]                  flags,
  output logic [STAGES*(FLAGS_W+INSTR_W)-1:0] rom_addr,
  input  logic [STAGES*CTRL_W-1:0]            rom_data,
  output logic [STAGES*CTRL_W-1:0]            controls_out,
  output logic [STAGES*INSTR_W-1:0]           instr_out,
  output logic [STAGES-1:0]                   valid_out,
  output logic [RCOUNT_W-1:0]                 retired_count
);

  localparam int ADDR_W = FLAGS_W + INSTR_W;
  localparam int LAST   = STAGES - 1;

  logic [INSTR_W-1:0]  r_instr [STAGES];
  logic [STAGES-1:0]   r_valid;
  logic [RCOUNT_W-1:0] r_retired;

  logic [INSTR_W-1:0]  w_instr_nxt [STAGES];
  logic [STAGES-1:0]   w_valid_nxt;
  logic                w_advance;
  logic                w_retire;

  assign w_advance = !stall;

  // A flush squashes the instruction in that stage: on an advance it leaves as a bubble,
  // on a stall it turns into a bubble in place.
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      w_instr_nxt[s] = r_instr[s];
      w_valid_nxt[s] = r_valid[s];
    end
    if (w_advance) begin
      if (fetch_suppress) begin
        w_instr_nxt[0] = NOP_INSTR;
        w_valid_nxt[0] = 1'b0;
      end else begin
        w_instr_nxt[0] = instruction;
        w_valid_nxt[0] = 1'b1;
      end
      for (int s = 1; s < STAGES; s++) begin
        if (flush[s-1]) begin
          w_instr_nxt[s] = NOP_INSTR;
          w_valid_nxt[s] = 1'b0;
        end else begin
          w_instr_nxt[s] = r_instr[s-1];
          w_valid_nxt[s] = r_valid[s-1];
        end
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (flush[s]) begin
          w_instr_nxt[s] = NOP_INSTR;
          w_valid_nxt[s] = 1'b0;
        end
      end
    end
  end

  // An instruction retires only if it actually leaves the last stage unsquashed.
  assign w_retire = w_advance & r_valid[LAST] & ~flush[LAST];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int s = 0; s < STAGES; s++) begin
        r_instr[s] <= NOP_INSTR;
      end
      r_valid   <= '0;
      r_retired <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        r_instr[s] <= w_instr_nxt[s];
      end
      r_valid <= w_valid_nxt;
      if (w_retire) begin
        r_retired <= r_retired + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage_out
    assign rom_addr[g*ADDR_W +: ADDR_W]      = {flags, r_instr[g]};
    assign instr_out[g*INSTR_W +: INSTR_W]   = r_instr[g];
    assign controls_out[g*CTRL_W +: CTRL_W]  = r_valid[g] ? rom_data[g*CTRL_W +: CTRL_W]
                                                          : IDLE_CONTROLS;
  end

  assign valid_out     = r_valid;
  assign retired_count = r_retired;

endmodule

// File: tb/tb_control_pipeline.sv
// Directed bench for control_pipeline (STAGES=2, RCOUNT_W=4): driver pushes hand-computed
// per-edge expectations, a monitor pops and compares them just after each rising edge.
module tb_control_pipeline;

  localparam int W = 2 + 8 + 8 + 32 + 4 + 30;

  logic        clk;
  logic        reset_n;
  logic [7:0]  instruction;
  logic        fetch_suppress;
  logic        stall;
  logic [1:0]  flush;
  logic [6:0]  flags;
  logic [29:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] controls_out;
  logic [15:0] instr_out;
  logic [1:0]  valid_out;
  logic [3:0]  retired_count;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  bit done   = 0;

  control_pipeline #(.STAGES(2), .RCOUNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .instruction(instruction),
    .fetch_suppress(fetch_suppress), .stall(stall), .flush(flush), .flags(flags),
    .rom_addr(rom_addr), .rom_data(rom_data), .controls_out(controls_out),
    .instr_out(instr_out), .valid_out(valid_out), .retired_count(retired_count)
  );

  // Bench ROM: control word = {0, flags, instr} of the addressed stage.
  assign rom_data[15:0]  = {1'b0, rom_addr[14:8], rom_addr[7:0]};
  assign rom_data[31:16] = {1'b0, rom_addr[29:23], rom_addr[22:15]};

  // clock / reset
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // One edge: drive inputs, push expected state after the edge.
  task automatic step(input logic rst_n, input logic [7:0] ins, input logic sup,
                      input logic stl, input logic [1:0] fl, input logic [6:0] fg,
                      input logic [1:0] ev, input logic [7:0] ei1, input logic [7:0] ei0,
                      input logic [3:0] ecnt);
    logic [15:0] c1, c0;
    @(negedge clk);
    reset_n = rst_n; instruction = ins; fetch_suppress = sup;
    stall = stl; flush = fl; flags = fg;
    c1 = ev[1] ? {1'b0, fg, ei1} : 16'hFFFF;
    c0 = ev[0] ? {1'b0, fg, ei0} : 16'hFFFF;
    exp_q.push_back({ev, ei1, ei0, c1, c0, ecnt, fg, ei1, fg, ei0});
  endtask

  // monitor / scoreboard
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("valid_out",     {30'd0, valid_out},     {30'd0, e[83:82]});
        check("instr_out",     {16'd0, instr_out},     {16'd0, e[81:66]});
        check("controls_out",  controls_out,           e[65:34]);
        check("retired_count", {28'd0, retired_count}, {28'd0, e[33:30]});
        check("rom_addr",      {2'd0, rom_addr},       {2'd0, e[29:0]});
      end
    end
  end

  // driver
  initial begin
    reset_n = 0; instruction = 0; fetch_suppress = 0; stall = 0; flush = 0; flags = 0;
    // reset for two edges
    step(0, 8'h00, 0, 0, 2'b00, 0, 2'b00, 8'h00, 8'h00, 0);
    step(0, 8'h00, 0, 0, 2'b00, 0, 2'b00, 8'h00, 8'h00, 0);
    // flow
    step(1, 8'h69, 0, 0, 2'b00, 0, 2'b01, 8'h00, 8'h69, 0);
    step(1, 8'h88, 0, 0, 2'b00, 0, 2'b11, 8'h69, 8'h88, 0);
    step(1, 8'h26, 0, 0, 2'b00, 0, 2'b11, 8'h88, 8'h26, 1);
    // stall three edges, instruction ignored
    for (int i = 0; i < 3; i++)
      step(1, 8'hAA, 0, 1, 2'b00, 0, 2'b11, 8'h88, 8'h26, 1);
    step(1, 8'h33, 0, 0, 2'b00, 0, 2'b11, 8'h26, 8'h33, 2);
    // flush stage 0 on advance: 26 never retires
    step(1, 8'h26, 0, 0, 2'b00, 0, 2'b11, 8'h33, 8'h26, 3);
    step(1, 8'h44, 0, 0, 2'b01, 0, 2'b01, 8'h00, 8'h44, 4);
    step(1, 8'h55, 0, 0, 2'b00, 0, 2'b11, 8'h44, 8'h55, 4);
    // flush under stall: bubble in place, per stage
    step(1, 8'hAA, 0, 1, 2'b01, 0, 2'b10, 8'h44, 8'h00, 4);
    step(1, 8'hAA, 0, 1, 2'b10, 0, 2'b00, 8'h00, 8'h00, 4);
    // fetch suppress, then flags into rom_addr
    step(1, 8'h77, 1, 0, 2'b00, 0, 2'b00, 8'h00, 8'h00, 4);
    step(1, 8'h26, 0, 0, 2'b00, 0, 2'b01, 8'h00, 8'h26, 4);
    step(1, 8'hAA, 0, 1, 2'b00, 7'h04, 2'b01, 8'h00, 8'h26, 4);
    // flush of last stage blocks its retire
    step(1, 8'h11, 0, 0, 2'b00, 0, 2'b11, 8'h26, 8'h11, 4);
    step(1, 8'h12, 0, 0, 2'b10, 0, 2'b11, 8'h11, 8'h12, 4);
    // sixteen retires wrap the 4-bit counter through 0 back to 4
    step(1, 8'hA0, 0, 0, 2'b00, 0, 2'b11, 8'h12, 8'hA0, 5);
    for (int k = 1; k < 16; k++)
      step(1, 8'hA0 + 8'(k), 0, 0, 2'b00, 0, 2'b11, 8'hA0 + 8'(k - 1), 8'hA0 + 8'(k),
           4'((5 + k) % 16));
    // mid-run reset beats stall/flush with both stages valid
    step(0, 8'hBB, 0, 1, 2'b11, 0, 2'b00, 8'h00, 8'h00, 0);
    step(1, 8'h5A, 0, 0, 2'b00, 0, 2'b01, 8'h00, 8'h5A, 0);
    step(1, 8'h5B, 0, 0, 2'b00, 0, 2'b11, 8'h5A, 8'h5B, 0);
    step(1, 8'h5C, 0, 0, 2'b00, 0, 2'b11, 8'h5B, 8'h5C, 1);
    @(negedge clk);
    @(negedge clk);
    done = 1;
  end

  // final report
  initial begin
    wait (done);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual=%0d required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
